// File: rtl/dsp_issue_ctrl_pkg.sv
// Shared definitions for the DSP issue controller: FSM encodings and phase slot indices.
package dsp_issue_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_COLLECT = 2'd2,
    ST_DONE    = 2'd3
  } dsp_state_e;

  localparam int PH_LO   = 0;
  localparam int PH_MID  = 1;
  localparam int PH_FULL = 2;

endpackage

// File: rtl/dsp_issue_ctrl_golden_mult.sv
// Reference products for the three DSP phases. Operands are extended to the full
// result width before multiplying, so the truncated product is exact for both
// signed and unsigned operation.
module dsp_golden_mult #(
  parameter int N = 8,
  parameter int M = 8
) (
  input  logic           sign,
  input  logic [N-1:0]   a,
  input  logic [M-1:0]   b,
  output logic [N+M-1:0] exp_lo,
  output logic [N+M-1:0] exp_mid,
  output logic [N+M-1:0] exp_full
);

  localparam int W = N + M;

  logic [W-1:0] a_x;
  logic [W-1:0] b_x;
  logic [W-1:0] a_lo_x;
  logic [W-1:0] b_lo_x;

  // Sign- or zero-extend full operands and their low halves, then form the products.
  always_comb begin
    a_x      = {{M{sign & a[N-1]}}, a};
    b_x      = {{N{sign & b[M-1]}}, b};
    a_lo_x   = {{(W-N/2){sign & a[N/2-1]}}, a[N/2-1:0]};
    b_lo_x   = {{(W-M/2){sign & b[M/2-1]}}, b[M/2-1:0]};
    exp_lo   = a_lo_x * b_lo_x;
    exp_mid  = a_x * b_lo_x;
    exp_full = a_x * b_x;
  end

endmodule

// File: rtl/dsp_issue_ctrl.sv
// Initiator for the multi-phase DSP multiply: issues one operand set, collects the
// three strobed phase results, checks them against local golden products and hands
// them back over a valid/ready result port.
//
// state   | meaning
// IDLE    | in_ready high, waiting for an operand request
// ISSUE   | one-cycle dsp_start pulse, capture index and timer re-armed
// COLLECT | capturing dsp_out the cycle after each dsp_cmp strobe
// DONE    | res_valid held with stable results until res_ready
module dsp_issue_ctrl
  import dsp_issue_ctrl_pkg::*;
#(
  parameter int N       = 8,
  parameter int M       = 8,
  parameter int TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           in_sign,
  input  logic [N-1:0]   in_a,
  input  logic [M-1:0]   in_b,
  output logic           dsp_start,
  output logic           dsp_sign,
  output logic [N-1:0]   dsp_aa,
  output logic [M-1:0]   dsp_bb,
  input  logic [N+M-1:0] dsp_out,
  input  logic           dsp_cmp,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [N+M-1:0] res_lo,
  output logic [N+M-1:0] res_mid,
  output logic [N+M-1:0] res_full,
  output logic [2:0]     res_err,
  output logic           res_timeout
);

  localparam int TW = $clog2(TIMEOUT);

  dsp_state_e     state_q;
  dsp_state_e     state_d;
  logic [1:0]     cap_idx_q;
  logic [TW-1:0]  tmr_q;
  logic           cmp_d_q;
  logic           accept;
  logic           cap;
  logic           last_cap;
  logic           tmr_tc;
  logic [N+M-1:0] exp_lo;
  logic [N+M-1:0] exp_mid;
  logic [N+M-1:0] exp_full;
  logic [N+M-1:0] exp_sel;

  // The held DSP operand registers double as the golden operand registers.
  dsp_golden_mult #(.N(N), .M(M)) u_golden (
    .sign     (dsp_sign),
    .a        (dsp_aa),
    .b        (dsp_bb),
    .exp_lo   (exp_lo),
    .exp_mid  (exp_mid),
    .exp_full (exp_full)
  );

  assign accept   = (state_q == ST_IDLE) && in_valid && in_ready;
  assign cap      = (state_q == ST_COLLECT) && cmp_d_q && (cap_idx_q <= 2'(PH_FULL));
  assign last_cap = cap && (cap_idx_q == 2'(PH_FULL));
  assign tmr_tc   = (tmr_q == '0);

  // Golden value for the slot currently being captured.
  always_comb begin
    exp_sel = '0;
    case (cap_idx_q)
      2'(PH_LO):   exp_sel = exp_lo;
      2'(PH_MID):  exp_sel = exp_mid;
      2'(PH_FULL): exp_sel = exp_full;
      default:     exp_sel = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_d   = state_q;
    dsp_start = 1'b0;
    res_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        dsp_start = 1'b1;
        state_d   = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (last_cap || tmr_tc) state_d = ST_DONE;
      end
      ST_DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered in_ready keeps it low during reset and rises the cycle IDLE is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) in_ready <= 1'b0;
    else        in_ready <= (state_d == ST_IDLE);
  end

  // Operand capture, phase collection, checking and abandon timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dsp_sign    <= 1'b0;
      dsp_aa      <= '0;
      dsp_bb      <= '0;
      cap_idx_q   <= '0;
      tmr_q       <= '0;
      cmp_d_q     <= 1'b0;
      res_lo      <= '0;
      res_mid     <= '0;
      res_full    <= '0;
      res_err     <= '0;
      res_timeout <= 1'b0;
    end else begin
      if (accept) begin
        dsp_sign <= in_sign;
        dsp_aa   <= in_a;
        dsp_bb   <= in_b;
      end
      if (state_q == ST_ISSUE) begin
        // Timer counts from the start cycle; it reaches terminal count on the
        // TIMEOUT-th cycle after start.
        cap_idx_q   <= '0;
        tmr_q       <= TW'(TIMEOUT - 2);
        cmp_d_q     <= 1'b0;
        res_lo      <= '0;
        res_mid     <= '0;
        res_full    <= '0;
        res_err     <= '0;
        res_timeout <= 1'b0;
      end
      if (state_q == ST_COLLECT) begin
        cmp_d_q <= dsp_cmp;
        if (!tmr_tc) tmr_q <= tmr_q - TW'(1);
        if (cap) begin
          case (cap_idx_q)
            2'(PH_LO):   res_lo   <= dsp_out;
            2'(PH_MID):  res_mid  <= dsp_out;
            2'(PH_FULL): res_full <= dsp_out;
            default:     ;
          endcase
          res_err[cap_idx_q] <= (dsp_out != exp_sel);
          cap_idx_q          <= cap_idx_q + 2'd1;
        end
        if (tmr_tc && !last_cap) res_timeout <= 1'b1;
      end
    end
  end

endmodule
